// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: source codes, FSM states
// and the latched-winner payload.
package wb_pkg;

  localparam int unsigned SRC_W = 4;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [SRC_W-1:0] {
    SRC_EXC   = 4'd0,
    SRC_MEM   = 4'd1,
    SRC_ALU   = 4'd2,
    SRC_HI    = 4'd3,
    SRC_LO    = 4'd4,
    SRC_SHIFT = 4'd5,
    SRC_HALF  = 4'd6,
    SRC_BYTE  = 4'd7,
    SRC_IMM   = 4'd8
  } src_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEMWAIT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [REG_W-1:0] dst;
  } wb_win_t;

  // Sources whose data arrives from memory and needs the latency window.
  function automatic logic is_load(logic [SRC_W-1:0] code);
    return (code == SRC_MEM) || (code == SRC_HALF) || (code == SRC_BYTE);
  endfunction

endpackage

// File: rtl/wb_pick.sv
// Combinational winner select: first set req bit at or after ptr, wrapping.
// A constant ptr of 0 degenerates to lowest-index fixed priority.
module wb_pick
  import wb_pkg::*;
#(
  parameter int unsigned NSRC = 9
) (
  input  logic [NSRC-1:0]  req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] win_c,
  output logic             valid_c
);

  localparam int unsigned IDX_W = $clog2(NSRC);

  logic [4:0]       sum;
  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    win_c   = '0;
    valid_c = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = int'(NSRC) - 1; k >= 0; k--) begin
      sum = 5'(ptr) + 5'(k);
      if (sum >= 5'(NSRC)) sum = sum - 5'(NSRC);
      idx = IDX_W'(sum);
      if (req[idx]) begin
        win_c   = SRC_W'(sum);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: picks one of nine writeback sources, waits out
// memory latency for loads, then issues one registered write. WB_ROUND_ROBIN_EN selects round robin.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NSRC    = 9,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC*REG_W-1:0] dst_flat,
  output logic [NSRC-1:0]       gnt,
  output logic [SRC_W-1:0]      regdata_sel,
  output logic [REG_W-1:0]      reg_dst,
  output logic                  reg_write,
  output logic                  busy
);

  state_e           state_q, state_d;
  wb_win_t          win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NSRC-1:0]  gnt_q, gnt_d;
  logic [SRC_W-1:0] sel_q, sel_d;
  logic [REG_W-1:0] reg_dst_q, reg_dst_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;

  logic [SRC_W-1:0] ptr_c;
  logic [SRC_W-1:0] pick_win_c;
  logic             pick_valid_c;
  logic [REG_W-1:0] pick_dst_c;
  logic             wr_go_c;
  wb_win_t          wr_win_c;

`ifdef WB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] ptr_q, ptr_d;
  assign ptr_c = ptr_q;
`else
  assign ptr_c = '0;
`endif

  wb_pick #(.NSRC(NSRC)) u_pick (
    .req     (req),
    .ptr     (ptr_c),
    .win_c   (pick_win_c),
    .valid_c (pick_valid_c)
  );

  always_comb begin
    pick_dst_c = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (pick_win_c == SRC_W'(i)) pick_dst_c = dst_flat[i*REG_W +: REG_W];
    end
  end

  // Next state; output registers are loaded on the transition into WRITE.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    sel_d     = sel_q;
    reg_dst_d = reg_dst_q;
    we_d      = 1'b0;
    wr_go_c   = 1'b0;
    wr_win_c  = win_q;
`ifdef WB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          win_d = '{src: pick_win_c, dst: pick_dst_c};
          if (is_load(pick_win_c) && (MEM_LAT != 0)) begin
            state_d = MEMWAIT;
            cnt_d   = CNT_W'(MEM_LAT - 1);
          end else begin
            state_d  = WRITE;
            wr_go_c  = 1'b1;
            wr_win_c = win_d;
          end
        end
      end
      MEMWAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = WRITE;
          wr_go_c = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_go_c) begin
      gnt_d     = NSRC'(1) << wr_win_c.src;
      sel_d     = wr_win_c.src;
      reg_dst_d = wr_win_c.dst;
      we_d      = (wr_win_c.dst != '0);
`ifdef WB_ROUND_ROBIN_EN
      ptr_d     = (wr_win_c.src == SRC_W'(NSRC - 1)) ? '0 : wr_win_c.src + SRC_W'(1);
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      reg_dst_q <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef WB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      reg_dst_q <= reg_dst_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
`ifdef WB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign regdata_sel = sel_q;
  assign reg_dst     = reg_dst_q;
  assign reg_write   = we_q;
  assign busy        = busy_q;

endmodule
